// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // One-hot states of the transmit-buffer launcher
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_LOAD = 3'b010,
    S_SEND = 3'b100
  } tx_buf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              overflow_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              accept;

  assign full_o     = (count == DEPTH[AW:0]);
  assign empty_o    = (count == '0);
  assign count_o    = count;
  assign accept     = push_i && (!full_o || pop_i);
  assign overflow_o = push_i && !accept;
  assign rd_data_o  = mem[rd_ptr];

  // Storage array: written on accepted pushes only, never reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_i) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer in front of uart_tx: queues bytes from a producer and launches
// one frame per byte with a single-cycle trigger, holding the byte until done.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o,
  output logic              overflow_o,
  output logic              buf_busy_o,
  output logic              tx_trigger_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_busy_i,
  input  logic              tx_done_i
);

  tx_buf_state_e     state;
  logic              pop;
  logic              empty;
  logic [DATA_W-1:0] head;

  // Only pop when something is queued and uart_tx is ready, so an empty pop cannot happen
  assign pop        = (state == S_IDLE) && !empty && !tx_busy_i;
  assign empty_o    = empty;
  assign buf_busy_o = !empty || (state != S_IDLE);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (wr_en_i),
    .wr_data_i  (wr_data_i),
    .pop_i      (pop),
    .rd_data_o  (head),
    .full_o     (full_o),
    .empty_o    (empty),
    .count_o    (level_o),
    .overflow_o (overflow_o)
  );

  // Launcher FSM: the held byte only changes when a new frame is started,
  // because uart_tx samples it during its START cycle after the trigger
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      tx_trigger_o <= 1'b0;
      tx_data_o    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx_trigger_o <= 1'b0;
          if (pop) begin
            state        <= S_LOAD;
            tx_trigger_o <= 1'b1;
            tx_data_o    <= head;
          end
        end
        S_LOAD: begin
          tx_trigger_o <= 1'b0;
          state        <= S_SEND;
        end
        S_SEND: begin
          tx_trigger_o <= 1'b0;
          if (tx_done_i) begin
            state <= S_IDLE;
          end
        end
        default: begin
          tx_trigger_o <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a small behavioural uart_tx and line monitor.
module tb_uart_tx_buffer;

  localparam int P = 2;  // clocks per serial bit in the uart_tx model

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, buf_busy, trig;
  logic [4:0] level;
  logic [7:0] txd;
  logic       force_busy = 1'b0;
  logic       force_done = 1'b0;
  logic       tx_busy, tx_done;

  // uart_tx model state
  logic       m_busy, m_done, line;
  logic [9:0] frame;
  logic [3:0] bitidx;
  int         sub;

  // monitor state
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  logic [7:0] trig_q[$];
  int         trig_cyc_q[$];
  logic [9:0] rx_frame = '0;
  int         rx_bits = 0;
  logic [7:0] hold_ref = 8'h00;
  int         hold_bad = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tx_busy = force_busy | m_busy;
  assign tx_done = m_done | force_done;

  uart_tx_buffer #(.DATA_W(8), .DEPTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .overflow_o   (overflow),
    .buf_busy_o   (buf_busy),
    .tx_trigger_o (trig),
    .tx_data_o    (txd),
    .tx_busy_i    (tx_busy),
    .tx_done_i    (tx_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: start bit, 8 data bits LSB first, stop bit, then a done pulse
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_busy <= 1'b0;
      line   <= 1'b1;
      sub    <= 0;
      bitidx <= 4'd0;
      frame  <= 10'h3FF;
    end else if (!m_busy) begin
      if (trig) begin
        m_busy <= 1'b1;
        frame  <= {1'b1, txd, 1'b0};
        line   <= 1'b0;
        bitidx <= 4'd0;
        sub    <= 0;
      end
    end else if (sub == P - 1) begin
      sub <= 0;
      if (bitidx == 4'd9) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        line   <= 1'b1;
      end else begin
        bitidx <= bitidx + 4'd1;
        line   <= frame[bitidx + 4'd1];
      end
    end else begin
      sub <= sub + 1;
    end
  end

  // Line and handshake monitor
  always @(negedge clk) begin
    if (m_done) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (trig) begin
      trig_q.push_back(txd);
      trig_cyc_q.push_back(cyc);
      hold_ref = txd;
      rx_bits  = 0;
    end
    if (m_busy && sub == P - 1 && rx_bits < 10) begin
      rx_frame = {line, rx_frame[9:1]};
      rx_bits  = rx_bits + 1;
    end
    if (m_busy && txd !== hold_ref) hold_bad = hold_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trigger got %b want 0", trig); end
    checks++; if (txd !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", txd); end
    checks++; if (buf_busy !== 1'b0) begin errors++; $display("FAIL reset_buf_busy got %b want 0", buf_busy); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    int base, target, wc, hb;
    bit ok;
    base   = trig_q.size();
    target = done_cnt + 1;
    hb     = hold_bad;
    wr_en = 1'b1; wr_data = 8'hA5; wc = cyc;
    tick();
    wr_en = 1'b0;
    wait_frames(target, 200, ok);
    repeat (3) tick();
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got %0d frames want %0d", done_cnt, target); end
    checks++; if (trig_q.size() - base !== 1) begin errors++; $display("FAIL single_trigger_count got %0d want 1", trig_q.size() - base); end
    if (trig_q.size() > base) begin
      checks++; if (trig_q[base] !== 8'hA5) begin errors++; $display("FAIL single_tx_data got %h want a5", trig_q[base]); end
      // wr_en in cycle k, stored at edge k+1, popped at edge k+2: trigger seen in cycle k+2
      checks++; if (trig_cyc_q[base] - wc !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", trig_cyc_q[base] - wc); end
    end
    checks++; if (rx_bits !== 10 || rx_frame !== 10'b1_10100101_0) begin errors++; $display("FAIL single_line got %b (%0d bits) want 1101001010", rx_frame, rx_bits); end
    checks++; if (hold_bad !== hb) begin errors++; $display("FAIL single_hold got %0d changes want 0", hold_bad - hb); end
    checks++; if (txd !== 8'hA5) begin errors++; $display("FAIL single_data_after_done got %h want a5", txd); end
    checks++; if (buf_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", buf_busy); end
  endtask

  task automatic test_back_to_back();
    int base, target, bad;
    bit ok;
    logic [7:0] exp;
    base = trig_q.size();
    force_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL b2b_level_loaded got %0d want 3", level); end
    tick();
    target = done_cnt + 3;
    force_busy = 1'b0;
    wait_frames(target, 300, ok);
    repeat (3) tick();
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_timeout got %0d want %0d", done_cnt, target); end
    checks++; if (trig_q.size() - base !== 3) begin errors++; $display("FAIL b2b_trigger_count got %0d want 3", trig_q.size() - base); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      exp = 8'(i + 1);
      if (base + i < trig_q.size() && trig_q[base + i] !== exp) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_order got %0d wrong bytes want 0", bad); end
    // done in cycle D, IDLE at edge D+1, LOAD at edge D+2: trigger seen in cycle D+2
    for (int i = 1; i < 3; i++) begin
      if (base + i < trig_cyc_q.size()) begin
        checks++;
        if (trig_cyc_q[base + i] - trig_cyc_q[base + i - 1] < 2 * 10 + 3 ||
            trig_cyc_q[base + i] - trig_cyc_q[base + i - 1] > 2 * 10 + 4) begin
          errors++; $display("FAIL b2b_spacing got %0d cycles want 23..24", trig_cyc_q[base + i] - trig_cyc_q[base + i - 1]);
        end
      end
    end
    checks++; if (trig_cyc_q[trig_cyc_q.size() - 1] - last_done_cyc > 0 && done_cnt == target &&
                  level !== 5'd0) begin errors++; $display("FAIL b2b_level_drained got %0d want 0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_done_to_trigger_gap();
    int base, target, d0;
    bit ok;
    base = trig_q.size();
    force_busy = 1'b1;
    wr_en = 1'b1; wr_data = 8'h44; tick();
    wr_data = 8'h55; tick();
    wr_en = 1'b0;
    target = done_cnt + 1;
    force_busy = 1'b0;
    wait_frames(target, 100, ok);
    d0 = last_done_cyc;
    wait_frames(target + 1, 100, ok);
    repeat (3) tick();
    checks++; if (!ok || trig_q.size() - base !== 2) begin errors++; $display("FAIL gap_frames got %0d want 2", trig_q.size() - base); end
    else begin
      checks++; if (trig_cyc_q[base + 1] - d0 !== 2) begin errors++; $display("FAIL gap_done_to_trigger got %0d want 2", trig_cyc_q[base + 1] - d0); end
    end
  endtask

  task automatic test_overflow();
    int base;
    logic ov_any;
    base = trig_q.size();
    force_busy = 1'b1;
    ov_any = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      @(negedge clk);
      ov_any = ov_any | overflow;
      tick();
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (ov_any !== 1'b0) begin errors++; $display("FAIL ovf_early_pulse got %b want 0", ov_any); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at_16 got %b want 1", full); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level_16 got %0d want 16", level); end
    tick();
    wr_en = 1'b1; wr_data = 8'h20;
    @(negedge clk);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse_17th got %b want 1", overflow); end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_width got %b want 0", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level_kept got %0d want 16", level); end
    checks++; if (trig_q.size() !== base) begin errors++; $display("FAIL ovf_hold_no_trigger got %0d want 0", trig_q.size() - base); end
  endtask

  task automatic test_full_push_pop();
    int base, target, bad;
    bit ok;
    logic [7:0] exp;
    tick();
    base = trig_q.size();
    target = done_cnt + 17;
    wr_en = 1'b1; wr_data = 8'h21; force_busy = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_overflow got %b want 0", overflow); end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fpp_level got %0d want 16", level); end
    checks++; if (trig !== 1'b1 || txd !== 8'h10) begin errors++; $display("FAIL fpp_first_launch got trig %b data %h want 1 10", trig, txd); end
    wait_frames(target, 1500, ok);
    repeat (3) tick();
    checks++; if (!ok || trig_q.size() - base !== 17) begin errors++; $display("FAIL fpp_frame_count got %0d want 17", trig_q.size() - base); end
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      exp = (i < 16) ? 8'(8'h10 + i) : 8'h21;
      if (base + i >= trig_q.size() || trig_q[base + i] !== exp) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fpp_wrap_order got %0d wrong bytes want 0", bad); end
    checks++; if (empty !== 1'b1 || buf_busy !== 1'b0) begin errors++; $display("FAIL fpp_drained got empty %b busy %b want 1 0", empty, buf_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int b2;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (level !== 5'd4 || m_busy !== 1'b1) begin errors++; $display("FAIL rmf_setup got level %0d busy %b want 4 1", level, m_busy); end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (empty !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL rmf_fifo_cleared got empty %b level %0d want 1 0", empty, level); end
    checks++; if (trig !== 1'b0 || txd !== 8'h00) begin errors++; $display("FAIL rmf_outputs got trig %b data %h want 0 00", trig, txd); end
    tick();
    rst = 1'b0;
    b2 = trig_q.size();
    repeat (100) tick();
    checks++; if (trig_q.size() !== b2) begin errors++; $display("FAIL rmf_no_frames got %0d want 0", trig_q.size() - b2); end
  endtask

  task automatic test_spurious_done();
    int base, target;
    bit ok;
    base = trig_q.size();
    force_done = 1'b1;
    @(negedge clk);
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL spur_trigger got %b want 0", trig); end
    tick();
    force_done = 1'b0;
    repeat (3) tick();
    checks++; if (trig_q.size() !== base || buf_busy !== 1'b0) begin errors++; $display("FAIL spur_state got frames %0d busy %b want 0 0", trig_q.size() - base, buf_busy); end
    target = done_cnt + 1;
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    wait_frames(target, 100, ok);
    repeat (3) tick();
    checks++; if (!ok || trig_q.size() - base !== 1 || trig_q[trig_q.size() - 1] !== 8'h5A) begin errors++; $display("FAIL spur_followup got %0d frames want 1 of 5a", trig_q.size() - base); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_done_to_trigger_gap();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_frame();
    test_spurious_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got cyc %0d want completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
